// File: rtl/mips_pkg.sv
// mips_pkg: PC-source encodings, fetch FSM state type and reset PC shared by the MIPS core.
// The HALT state exists only when IFETCH_ALIGN_CHECK_EN is defined.
package mips_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BEQ = 2'b01;
    localparam logic [1:0] PC_JAL = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} fetch_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC} fetch_state_e;
`endif

endpackage

// File: rtl/ifetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for sequential, beq, jal and jr flow.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_src_i,
    input  logic        zero_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] br_target;

    assign pc_plus4_o = pc_i + 32'd4;
    assign br_target  = pc_plus4_o + {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_o;
        next_pc_o = (pc_src_i == PC_BEQ && zero_i) ? br_target :
                    (pc_src_i == PC_JAL)           ? {pc_plus4_o[31:28], imm26_i, 2'b00} :
                    (pc_src_i == PC_JR)            ? jr_target_i : pc_plus4_o;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register and request/ready fetch FSM feeding the decoder, advancing on retire.
// Optional IFETCH_ALIGN_CHECK_EN halts on a misaligned next PC and raises a sticky align_err.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        retire,
    input  logic [1:0]  pc_src,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        align_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  next_pc;

    next_pc_calc u_npc (
        .pc_i        (pc_q),
        .pc_src_i    (pc_src),
        .zero_i      (zero),
        .imm16_i     (imm16),
        .imm26_i     (imm26),
        .jr_target_i (jr_target),
        .next_pc_o   (next_pc),
        .pc_plus4_o  (pc_plus4)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;
    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) align_err_q <= 1'b0;
        else     align_err_q <= align_err_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        align_err_d = align_err_q;
`endif
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ready) begin
                inst_d  = imem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC:  if (retire) begin
                pc_d    = next_pc;
                state_d = ST_FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
                // pc still takes the faulting target so it is visible for debug
                if (next_pc[1:0] != 2'b00) begin
                    state_d     = ST_HALT;
                    align_err_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign inst_valid = (state_q == ST_EXEC);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized self-checking bench for ifetch_unit against a PC-rule reference model.
module tb_ifetch_unit;
    import mips_pkg::*;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        retire = 1'b0;
    logic [1:0]  pc_src = '0;
    logic        zero = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_pc = 32'h0000_3000;

    ifetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .retire     (retire),
        .pc_src     (pc_src),
        .zero       (zero),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS next-PC rules computed with plain arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] src,
                                             input logic z, input logic [15:0] i16,
                                             input logic [25:0] i26, input logic [31:0] jr);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (src == 2'd0) return seq;
        if (src == 2'd1) return z ? seq + 32'(int'($signed(i16)) * 4) : seq;
        if (src == 2'd2) return (seq & 32'hF000_0000) | (32'(i26) * 32'd4);
        return jr;
    endfunction

    task automatic do_instr(input logic [31:0] word, input logic [1:0] src, input logic z,
                            input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jr,
                            input int stall, input int hold);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            bad++;
            $display("FAIL fetch_start req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_pc);
        end
        for (int i = 0; i < stall; i++) begin
            imem_ready = 1'b0;
            retire = 1'($urandom_range(0, 1));
            pc_src = 2'($urandom);
            jr_target = $urandom;
            tick();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall req=%b addr=%h valid=%b expected 1 %h 0", imem_req, imem_addr, inst_valid, exp_pc);
            end
        end
        retire = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        total++;
        if (inst_valid !== 1'b1 || inst !== word || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
            bad++;
            $display("FAIL latch valid=%b inst=%h pc=%h pc4=%h expected 1 %h %h %h",
                     inst_valid, inst, pc, pc_plus4, word, exp_pc, exp_pc + 32'd4);
        end
        for (int i = 0; i < hold; i++) begin
            imem_ready = 1'b1;
            imem_rdata = ~word;
            tick();
            total++;
            if (inst_valid !== 1'b1 || inst !== word || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL exec_hold valid=%b inst=%h req=%b expected 1 %h 0", inst_valid, inst, imem_req, word);
            end
        end
        imem_ready = 1'b0;
        retire = 1'b1;
        pc_src = src;
        zero = z;
        imm16 = i16;
        imm26 = i26;
        jr_target = jr;
        tick();
        retire = 1'b0;
        pc_src = 2'($urandom);
        zero = 1'($urandom);
        imm16 = 16'($urandom);
        imm26 = 26'($urandom);
        jr_target = $urandom;
        exp_pc = ref_next(exp_pc, src, z, i16, i26, jr);
        total++;
        if (pc !== exp_pc || inst_valid !== 1'b0 ||
            imem_req !== !(ALIGN_ON && exp_pc[1:0] != 2'b00)) begin
            bad++;
            $display("FAIL retire pc=%h valid=%b req=%b expected pc=%h", pc, inst_valid, imem_req, exp_pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        total++;
        if (pc !== 32'h0000_3000 || inst !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || align_err !== 1'b0) begin
            bad++;
            $display("FAIL reset pc=%h inst=%h valid=%b req=%b err=%b", pc, inst, inst_valid, imem_req, align_err);
        end
        rst = 1'b0;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || inst_valid !== 1'b0 || inst !== 32'h0) begin
            bad++;
            $display("FAIL idle_to_fetch req=%b addr=%h valid=%b inst=%h", imem_req, imem_addr, inst_valid, inst);
        end
        imem_ready = 1'b0;
        exp_pc = 32'h0000_3000;
    endtask

    task automatic test_seq();
        do_instr(32'h2008_0001, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0, 0);
        total++;
        if (imem_addr !== 32'h0000_3004) begin
            bad++;
            $display("FAIL seq_addr got=%h expected=00003004", imem_addr);
        end
    endtask

    task automatic test_beq();
        do_instr(32'h0800_0000, PC_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 0, 0);
        do_instr(32'h1000_FFFC, PC_BEQ, 1'b1, 16'hFFFC, 26'h0, 32'h0, 0, 1);
        total++;
        if (pc !== 32'h0000_3004) begin
            bad++;
            $display("FAIL beq_taken got=%h expected=00003004", pc);
        end
        do_instr(32'h0800_0000, PC_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3010, 0, 0);
        do_instr(32'h1000_FFFC, PC_BEQ, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1, 0);
        total++;
        if (pc !== 32'h0000_3014) begin
            bad++;
            $display("FAIL beq_not_taken got=%h expected=00003014", pc);
        end
    endtask

    task automatic test_jal();
        do_instr(32'h0800_0000, PC_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3020, 0, 0);
        do_instr(32'h0C00_0C10, PC_JAL, 1'b0, 16'h0, 26'h0000C10, 32'h0, 0, 0);
        total++;
        if (pc !== 32'h0000_3040) begin
            bad++;
            $display("FAIL jal got=%h expected=00003040", pc);
        end
        do_instr(32'h03E0_0008, PC_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3100, 0, 0);
        total++;
        if (pc !== 32'h0000_3100) begin
            bad++;
            $display("FAIL jr got=%h expected=00003100", pc);
        end
    endtask

    task automatic test_stall();
        do_instr(32'h0000_0020, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 5, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_instr($urandom, 2'($urandom), 1'($urandom), 16'($urandom), 26'($urandom),
                     $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    task automatic test_misaligned_jr();
        do_instr(32'h03E0_0008, PC_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3102, 0, 0);
        if (ALIGN_ON) begin
            for (int i = 0; i < 3; i++) begin
                imem_ready = 1'b1;
                retire = 1'b1;
                tick();
                total++;
                if (align_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0000_3102) begin
                    bad++;
                    $display("FAIL halt err=%b req=%b valid=%b pc=%h expected 1 0 0 00003102", align_err, imem_req, inst_valid, pc);
                end
            end
            imem_ready = 1'b0;
            retire = 1'b0;
        end else begin
            total++;
            if (imem_addr !== 32'h0000_3102 || align_err !== 1'b0 || imem_req !== 1'b1) begin
                bad++;
                $display("FAIL misaligned_pass addr=%h err=%b req=%b expected 00003102 0 1", imem_addr, align_err, imem_req);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_pc = 32'h0000_3000;
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ready = 1'b0;
        rst = 1'b1;
        retire = 1'b1;
        pc_src = PC_JR;
        jr_target = 32'h0000_5000;
        tick();
        rst = 1'b0;
        retire = 1'b0;
        total++;
        if (pc !== 32'h0000_3000 || inst_valid !== 1'b0 || imem_req !== 1'b0 || align_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid pc=%h valid=%b req=%b err=%b", pc, inst_valid, imem_req, align_err);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            bad++;
            $display("FAIL refetch req=%b addr=%h expected 1 00003000", imem_req, imem_addr);
        end
        do_instr(32'h0000_0000, PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_seq();
        test_beq();
        test_jal();
        test_stall();
        test_random();
        test_misaligned_jr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
